// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one combinational ALU through a 3-state sequencer
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_sel,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             grant1;
    logic             accept;
    logic             illegal;

    // Arbitration: req1 wins when alone, or on a tie when req0 was served last
    always_comb begin
        grant1     = req1_valid && (!req0_valid || (RR_EN && !last_grant_q));
        accept     = (state_q == IDLE) && (req0_valid || req1_valid);
        req0_ready = accept && !grant1;
        req1_ready = accept && grant1;
        illegal    = !(alu_sel_q inside {4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                                         4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1111});
    end

    // Sequencer next state: latch winner, capture ALU result, hold response until taken
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        alu_sel_d    = alu_sel_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: if (accept) begin
                alu_sel_d = grant1 ? req1_sel : req0_sel;
                alu_a_d   = grant1 ? req1_a : req0_a;
                alu_b_d   = grant1 ? req1_b : req0_b;
                id_d      = grant1;
                state_d   = EXEC;
            end
            EXEC: begin
                rsp_data_d  = illegal ? '0 : alu_out;
                rsp_err_d   = illegal;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d  = 1'b0;
                last_grant_d = id_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight op and makes req0 win the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            alu_sel_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            alu_sel_q    <= alu_sel_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_sel   = alu_sel_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = id_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scoreboard bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_sel = '0, req1_sel = '0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]   alu_sel;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic         rsp_valid, rsp_id, rsp_err, busy;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_data;

    typedef struct packed {
        logic         id;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(W), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .busy(busy)
    );

    // Behavioural ALU; illegal codes produce garbage so the arbiter's masking is visible
    always_comb begin
        alu_out = 32'hDEADBEEF;
        case (alu_sel)
            4'b0000: alu_out = alu_a + alu_b;
            4'b1000: alu_out = alu_a - alu_b;
            4'b0001: alu_out = alu_a << alu_b[4:0];
            4'b0010: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b0011: alu_out = {31'd0, alu_a < alu_b};
            4'b0100: alu_out = alu_a ^ alu_b;
            4'b0101: alu_out = alu_a >> alu_b[4:0];
            4'b1101: alu_out = $signed(alu_a) >>> alu_b[4:0];
            4'b0110: alu_out = alu_a | alu_b;
            4'b0111: alu_out = alu_a & alu_b;
            4'b1111: alu_out = alu_b;
            default: alu_out = 32'hDEADBEEF;
        endcase
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic id, input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id) begin
            req1_sel = s; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_sel = s; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
    endtask

    // Waits for the given requester's ready, records the expected response, returns at the accept edge
    task automatic wait_grant(input logic id, input logic [W-1:0] d, input logic e);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (id ? req1_ready : req0_ready) got = 1'b1;
            else @(negedge clk);
        end
        chk("grant", {31'd0, got}, 32'd1);
        if (got) begin
            chk("other_ready", {31'd0, id ? req0_ready : req1_ready}, 32'd0);
            sb.push_back('{id: id, data: d, err: e});
            @(posedge clk);
        end
    endtask

    task automatic issue(input logic id, input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] d, input logic e);
        @(negedge clk);
        drive(id, s, a, b);
        wait_grant(id, d, e);
        @(negedge clk);
        if (id) req1_valid = 1'b0;
        else req0_valid = 1'b0;
    endtask

    task automatic cmp_rsp(input string tag);
        exp_t x;
        chk({tag, "_sb"}, {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({tag, "_data"}, rsp_data, x.data);
            chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, x.id});
            chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, x.err});
        end
    endtask

    task automatic take_rsp(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        chk({tag, "_valid"}, {31'd0, got}, 32'd1);
        if (got) cmp_rsp(tag);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst_n = 1'b1;

        // 1: single ADD, latency check
        issue(1'b0, 4'b0000, 32'd10, 32'd5, 32'd15, 1'b0);
        chk("t1_exec_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t1_exec_busy", {31'd0, busy}, 32'd1);
        chk("t1_alu_a", alu_a, 32'd10);
        chk("t1_alu_b", alu_b, 32'd5);
        @(negedge clk);
        chk("t1_valid_n2", {31'd0, rsp_valid}, 32'd1);
        cmp_rsp("t1");

        // 2: three tied rounds after reset, grants 0,1,0
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        drive(1'b0, 4'b1000, 32'd10, 32'd5);
        drive(1'b1, 4'b0100, 32'd10, 32'd5);
        for (int r = 0; r < 3; r++) begin
            wait_grant(r == 1, (r == 1) ? 32'd15 : 32'd5, 1'b0);
            take_rsp("t2");
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("t2_idle", {31'd0, busy}, 32'd0);

        // 3: back-pressure in RESP with req1 waiting
        rsp_ready = 1'b0;
        issue(1'b0, 4'b0000, 32'd7, 32'd8, 32'd15, 1'b0);
        drive(1'b1, 4'b0111, 32'd12, 32'd10);
        @(negedge clk);
        chk("t3_valid", {31'd0, rsp_valid}, 32'd1);
        cmp_rsp("t3");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t3_hold_data", rsp_data, 32'd15);
            chk("t3_hold_id", {31'd0, rsp_id}, 32'd0);
            chk("t3_busy", {31'd0, busy}, 32'd1);
            chk("t3_rdy0", {31'd0, req0_ready}, 32'd0);
            chk("t3_rdy1", {31'd0, req1_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("t3_after_hs_rdy1", {31'd0, req1_ready}, 32'd1);
        chk("t3_after_hs_valid", {31'd0, rsp_valid}, 32'd0);
        wait_grant(1'b1, 32'd8, 1'b0);
        @(negedge clk);
        req1_valid = 1'b0;
        take_rsp("t3b");

        // 4: illegal sel then a legal op
        issue(1'b1, 4'b1001, 32'd3, 32'd4, 32'd0, 1'b1);
        chk("t4_alu_sel_driven", {28'd0, alu_sel}, 32'd9);
        take_rsp("t4_illegal");
        issue(1'b0, 4'b0110, 32'd3, 32'd4, 32'd7, 1'b0);
        take_rsp("t4_legal");

        // 5: signed/unsigned boundary operands
        issue(1'b0, 4'b0011, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 1'b0);
        take_rsp("t5_sltu");
        issue(1'b0, 4'b0010, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 1'b0);
        take_rsp("t5_slt");
        issue(1'b0, 4'b0111, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        take_rsp("t5_and");
        issue(1'b0, 4'b1000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        take_rsp("t5_sub");

        // 6: reset during EXEC drops the op
        @(negedge clk);
        drive(1'b0, 4'b0000, 32'd1, 32'd2);
        #1;
        chk("t6_rdy0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("t6_in_exec", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_alu_a", alu_a, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        drive(1'b0, 4'b0000, 32'd1, 32'd1);
        drive(1'b1, 4'b0000, 32'd2, 32'd2);
        wait_grant(1'b0, 32'd2, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        take_rsp("t6_tie");
        chk("t6_sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
